// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and defaults for the data-memory arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int c_DEFAULT_ADDR_W = 16;
    localparam int c_DEFAULT_DATA_W = 16;

    // Owner of an in-flight read, carried alongside the memory latency.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_BM   = 2'd2
    } owner_t;

    typedef enum logic [0:0] {
        NORMAL   = 1'b0,
        FORCE_BM = 1'b1
    } arbState_t;

endpackage
`default_nettype wire

// File: rtl/dmem_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dmem_rd_pipe
// Description : RD_LAT-deep owner-tag shift register tracking in-flight reads.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_rd_pipe
    import dmem_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  owner_t i_pushTag,
    output owner_t o_popTag
);

    owner_t r_stage [RD_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_stage[i] <= OWN_NONE;
            end
        end else begin
            r_stage[0] <= i_pushTag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    // Tail tag lines up with the cycle the memory presents its read data.
    assign o_popTag = r_stage[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Single-port data memory arbiter, CPU vs bitmap reader, with
//               starvation-bounded bitmap grant and tagged read return.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = c_DEFAULT_ADDR_W,
    parameter int DATA_W   = c_DEFAULT_DATA_W,
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              bm_req,
    input  logic [ADDR_W-1:0] bm_addr,
    output logic              bm_gnt,
    output logic              bm_rvalid,
    output logic [DATA_W-1:0] bm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                 c_CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_MAX = c_CNT_W'(MAX_WAIT);

    arbState_t          r_state;
    arbState_t          w_nextState;
    logic [c_CNT_W-1:0] r_waitCnt;
    logic [c_CNT_W-1:0] w_nextWaitCnt;
    logic               w_cpuGnt;
    logic               w_bmGnt;
    owner_t             w_pushTag;
    owner_t             w_popTag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= NORMAL;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
        end
    end

    // Grant, wait counter and next state kept in one process so the counter
    // can see this cycle's grant without a combinational loop between blocks.
    always_comb begin
        w_cpuGnt      = 1'b0;
        w_bmGnt       = 1'b0;
        w_nextWaitCnt = r_waitCnt;
        w_nextState   = r_state;

        if (cpu_req && bm_req) begin
            if (r_state == FORCE_BM) begin
                w_bmGnt = 1'b1;
            end else begin
                w_cpuGnt = 1'b1;
            end
        end else begin
            w_cpuGnt = cpu_req;
            w_bmGnt  = bm_req;
        end

        if (!bm_req || w_bmGnt) begin
            w_nextWaitCnt = '0;
        end else if (r_waitCnt != c_WAIT_MAX) begin
            w_nextWaitCnt = r_waitCnt + c_CNT_W'(1);
        end

        case (r_state)
            NORMAL: begin
                if (w_nextWaitCnt == c_WAIT_MAX) begin
                    w_nextState = FORCE_BM;
                end
            end
            FORCE_BM: begin
                if (w_bmGnt || !bm_req) begin
                    w_nextState = NORMAL;
                end
            end
            default: w_nextState = NORMAL;
        endcase
    end

    // Memory-side mux; the bitmap reader never writes.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        w_pushTag = OWN_NONE;
        if (w_cpuGnt) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            w_pushTag = cpu_we ? OWN_NONE : OWN_CPU;
        end else if (w_bmGnt) begin
            mem_en    = 1'b1;
            mem_addr  = bm_addr;
            w_pushTag = OWN_BM;
        end
    end

    assign cpu_stall = cpu_req && !w_cpuGnt;
    assign bm_gnt    = w_bmGnt;

    dmem_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rdPipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_pushTag (w_pushTag),
        .o_popTag  (w_popTag)
    );

    assign cpu_rvalid = (w_popTag == OWN_CPU);
    assign bm_rvalid  = (w_popTag == OWN_BM);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign bm_rdata   = bm_rvalid  ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a read
//               scoreboard and a fixed-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int c_ADDR_W   = 16;
    localparam int c_DATA_W   = 16;
    localparam int c_RD_LAT   = 2;
    localparam int c_MAX_WAIT = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                cpu_req = 1'b0;
    logic                cpu_we = 1'b0;
    logic [c_ADDR_W-1:0] cpu_addr = '0;
    logic [c_DATA_W-1:0] cpu_wdata = '0;
    logic                cpu_stall;
    logic                cpu_rvalid;
    logic [c_DATA_W-1:0] cpu_rdata;
    logic                bm_req = 1'b0;
    logic [c_ADDR_W-1:0] bm_addr = '0;
    logic                bm_gnt;
    logic                bm_rvalid;
    logic [c_DATA_W-1:0] bm_rdata;
    logic                mem_en;
    logic                mem_we;
    logic [c_ADDR_W-1:0] mem_addr;
    logic [c_DATA_W-1:0] mem_wdata;
    logic [c_DATA_W-1:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W   (c_ADDR_W),
        .DATA_W   (c_DATA_W),
        .RD_LAT   (c_RD_LAT),
        .MAX_WAIT (c_MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .bm_req     (bm_req),
        .bm_addr    (bm_addr),
        .bm_gnt     (bm_gnt),
        .bm_rvalid  (bm_rvalid),
        .bm_rdata   (bm_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        owner_t      own;
        logic [15:0] data;
        int          due;
    } expRead_t;

    expRead_t    expQ [$];
    int          nCmp = 0;
    int          nFail = 0;
    int          cyc = 0;
    logic        wrFlag [0:4095];
    logic [15:0] wrData [0:4095];
    logic [15:0] rdLine [c_RD_LAT];

    // Memory contents: a fixed pattern, with 0x0010 holding 0xBEEF.
    function automatic logic [15:0] patData(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] memRead(input logic [15:0] a);
        if (wrFlag[a[11:0]]) return wrData[a[11:0]];
        return patData(a);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-latency memory macro model; 0xDEAD on the bus when no read returns.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) wrFlag[i] <= 1'b0;
            for (int i = 0; i < c_RD_LAT; i++) rdLine[i] <= 16'hDEAD;
        end else begin
            rdLine[0] <= (mem_en && !mem_we) ? memRead(mem_addr) : 16'hDEAD;
            for (int i = 1; i < c_RD_LAT; i++) rdLine[i] <= rdLine[i-1];
            if (mem_en && mem_we) begin
                wrFlag[mem_addr[11:0]] <= 1'b1;
                wrData[mem_addr[11:0]] <= mem_wdata;
            end
        end
    end
    assign mem_rdata = rdLine[c_RD_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chkGrant(input string tag, input logic eStall, input logic eGnt,
                            input logic eEn, input logic eWe, input logic [15:0] eAddr);
        check({tag, "_stall"}, 32'(cpu_stall), 32'(eStall));
        check({tag, "_bmgnt"}, 32'(bm_gnt), 32'(eGnt));
        check({tag, "_memen"}, 32'(mem_en), 32'(eEn));
        check({tag, "_memwe"}, 32'(mem_we), 32'(eWe));
        check({tag, "_addr"}, 32'(mem_addr), 32'(eAddr));
    endtask

    task automatic chkIdle(input string tag);
        check({tag, "_stall"}, 32'(cpu_stall), 32'd0);
        check({tag, "_bmgnt"}, 32'(bm_gnt), 32'd0);
        check({tag, "_memen"}, 32'(mem_en), 32'd0);
        check({tag, "_memwe"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_crv"}, 32'(cpu_rvalid), 32'd0);
        check({tag, "_brv"}, 32'(bm_rvalid), 32'd0);
        check({tag, "_crd"}, 32'(cpu_rdata), 32'd0);
        check({tag, "_brd"}, 32'(bm_rdata), 32'd0);
        check({tag, "_waitcnt"}, 32'(dut.r_waitCnt), 32'd0);
        check({tag, "_state"}, 32'(dut.r_state), 32'(NORMAL));
    endtask

    task automatic pushRead(input owner_t o, input logic [15:0] d);
        expQ.push_back('{own: o, data: d, due: cyc + c_RD_LAT});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        bm_req  = 1'b0;
        repeat (n) nextCycle();
    endtask

    // Both requesters continuously active; bitmap wins every (MAX_WAIT+1)th cycle.
    task automatic runContention(input int n, input logic [15:0] cpuBase, input logic [15:0] bmBase);
        logic [15:0] cpuA;
        logic [15:0] bmA;
        logic        bmWin;
        cpuA = cpuBase;
        bmA  = bmBase;
        for (int k = 0; k < n; k++) begin
            cpu_req  = 1'b1;
            cpu_we   = 1'b0;
            bm_req   = 1'b1;
            cpu_addr = cpuA;
            bm_addr  = bmA;
            bmWin    = ((k % (c_MAX_WAIT + 1)) == c_MAX_WAIT);
            @(negedge clk);
            chkGrant("contention", bmWin, bmWin, 1'b1, 1'b0, bmWin ? bmA : cpuA);
            if (bmWin) pushRead(OWN_BM, patData(bmA));
            else       pushRead(OWN_CPU, patData(cpuA));
            nextCycle();
            if (bmWin) bmA = bmA + 16'd1;
            else       cpuA = cpuA + 16'd1;
        end
    endtask

    // Read-return scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_rvalid || bm_rvalid) begin
                if (expQ.size() == 0) begin
                    check("unexpected_rvalid", {30'd0, cpu_rvalid, bm_rvalid}, 32'd0);
                end else begin
                    expRead_t e;
                    e = expQ.pop_front();
                    check("rv_owner", {30'd0, cpu_rvalid, bm_rvalid},
                          (e.own == OWN_CPU) ? 32'd2 : 32'd1);
                    check("rv_cycle", 32'(cyc), 32'(e.due));
                    if (e.own == OWN_CPU) begin
                        check("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                        check("bm_rdata_quiet", 32'(bm_rdata), 32'd0);
                    end else begin
                        check("bm_rdata", 32'(bm_rdata), 32'(e.data));
                        check("cpu_rdata_quiet", 32'(cpu_rdata), 32'd0);
                    end
                end
            end else begin
                check("rdata_idle", {cpu_rdata, bm_rdata}, 32'd0);
                if (expQ.size() > 0 && expQ[0].due <= cyc) begin
                    check("missing_rvalid", 32'd0, 32'd1);
                    void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chkIdle("reset");
        rst_n = 1'b1;
        nextCycle();

        // CPU-only read.
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0010;
        @(negedge clk);
        chkGrant("cpu_rd", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010);
        pushRead(OWN_CPU, 16'hBEEF);
        nextCycle();
        idleCycles(3);

        // Bitmap-only back-to-back reads.
        for (int i = 0; i < 3; i++) begin
            bm_req  = 1'b1;
            bm_addr = 16'(16'h0100 + i);
            @(negedge clk);
            chkGrant("bm_rd", 1'b0, 1'b1, 1'b1, 1'b0, 16'(16'h0100 + i));
            pushRead(OWN_BM, patData(16'(16'h0100 + i)));
            nextCycle();
        end
        idleCycles(3);

        // Continuous contention: forced bitmap grant at cycles 4 and 9.
        runContention(10, 16'h0030, 16'h0200);
        idleCycles(3);

        // CPU read then bitmap read on consecutive cycles.
        cpu_req  = 1'b1;
        cpu_addr = 16'h0040;
        @(negedge clk);
        chkGrant("ilv_cpu", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0040);
        pushRead(OWN_CPU, patData(16'h0040));
        nextCycle();
        cpu_req = 1'b0;
        bm_req  = 1'b1;
        bm_addr = 16'h0300;
        @(negedge clk);
        chkGrant("ilv_bm", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0300);
        pushRead(OWN_BM, patData(16'h0300));
        nextCycle();
        idleCycles(3);

        // CPU write (no rvalid), then read it back.
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0020;
        cpu_wdata = 16'h1234;
        @(negedge clk);
        chkGrant("cpu_wr", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0020);
        check("cpu_wr_wdata", 32'(mem_wdata), 32'h1234);
        nextCycle();
        cpu_we = 1'b0;
        @(negedge clk);
        chkGrant("cpu_rdback", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0020);
        pushRead(OWN_CPU, 16'h1234);
        nextCycle();
        idleCycles(3);

        // Bitmap request dropped before grant restarts the wait count.
        begin
            logic [15:0] cpuA;
            logic        bmWin;
            cpuA = 16'h0050;
            for (int k = 0; k < 8; k++) begin
                cpu_req  = 1'b1;
                cpu_addr = cpuA;
                bm_req   = (k != 2);
                bm_addr  = 16'h0400;
                bmWin    = (k == 7);
                @(negedge clk);
                chkGrant("bm_drop", bmWin, bmWin, 1'b1, 1'b0, bmWin ? 16'h0400 : cpuA);
                if (bmWin) pushRead(OWN_BM, patData(16'h0400));
                else       pushRead(OWN_CPU, patData(cpuA));
                nextCycle();
                if (!bmWin) cpuA = cpuA + 16'd1;
            end
        end
        idleCycles(3);

        // Reset one cycle after a CPU read issue, with bitmap wait built up.
        for (int k = 0; k < 3; k++) begin
            cpu_req  = 1'b1;
            cpu_addr = 16'(16'h0060 + k);
            bm_req   = 1'b1;
            bm_addr  = 16'h0500;
            @(negedge clk);
            chkGrant("pre_rst", 1'b1 ^ 1'b1, 1'b0, 1'b1, 1'b0, 16'(16'h0060 + k));
            if (k == 0) pushRead(OWN_CPU, patData(16'h0060));
            nextCycle();
        end
        cpu_req = 1'b0;
        bm_req  = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        chkIdle("mid_rst");
        nextCycle();
        @(negedge clk);
        chkIdle("mid_rst_hold");
        rst_n = 1'b1;
        nextCycle();
        idleCycles(3);
        runContention(5, 16'h0070, 16'h0600);
        idleCycles(4);

        check("queue_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the CPU load/store path and the bitmap streaming reader that feeds the display/note engine. Issues at most one memory access per cycle, gives the CPU default priority, forces a bitmap grant after a bounded wait, and routes fixed-latency read data back to whichever requester issued it. Sits between the CPU datapath (driven by the controller's DMemEn/DMemWrite decode) and the data memory macro.

## Interface
Parameters:
- ADDR_W, 16, memory word-address width
- DATA_W, 16, memory data width
- RD_LAT, 2, memory read latency in cycles (≥1)
- MAX_WAIT, 4, cycles a bitmap request may lose before it is forced (≥1)

Ports:
- clk  in  1  system clock; one clock, all state on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request (DMemEn)
- cpu_we  in  1  CPU write (DMemWrite)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_stall  out  1  cpu_req present but not granted this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- bm_req  in  1  bitmap reader read request, held until granted
- bm_addr  in  ADDR_W  bitmap read address
- bm_gnt  out  1  bitmap request issued this cycle
- bm_rvalid  out  1  bitmap read data valid
- bm_rdata  out  DATA_W  bitmap read data
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read issue

## Operation
- FSM, two states: NORMAL (CPU wins ties), FORCE_BM (bitmap wins ties). Reset → NORMAL.
- wait_cnt (registered, saturating at MAX_WAIT): +1 each cycle bm_req && !bm_gnt; cleared when bm_gnt or !bm_req. NORMAL→FORCE_BM when next wait_cnt == MAX_WAIT; FORCE_BM→NORMAL after the cycle bm_gnt is asserted, or if bm_req drops.
- Grant (combinational from current state and requests): only one requester → it wins; both → CPU in NORMAL, bitmap in FORCE_BM; none → mem_en=0.
- Granted requester drives mem_addr/mem_we/mem_wdata; bitmap always reads (mem_we=0). Idle: mem_addr/mem_wdata = 0.
- cpu_stall = cpu_req && !cpu_granted. CPU holds its request stable while stalled.
- Read-return pipe: RD_LAT-deep shift register of owner tags (NONE/CPU/BM). Read issue pushes owner; writes and idle push NONE. Tag at output: CPU → cpu_rvalid=1, cpu_rdata=mem_rdata; BM → bm_rvalid=1, bm_rdata=mem_rdata. Non-owner rdata = 0.
- CPU writes produce no rvalid.

## Timing
- Reset values: cpu_stall, bm_gnt, mem_en, mem_we = 0 (no requests during reset); mem_addr, mem_wdata, cpu_rdata, bm_rdata = 0; cpu_rvalid, bm_rvalid = 0; wait_cnt = 0; pipe all NONE.
- Issue latency: 0 cycles (grant and mem_en same cycle as request).
- Read latency: rvalid exactly RD_LAT cycles after the issue cycle; back-to-back reads return back-to-back, in issue order, interleaved between owners.
- Worst-case bitmap wait under continuous CPU traffic: MAX_WAIT cycles; granted in cycle MAX_WAIT counting the request cycle as 0.
- Reset asserted mid-operation: in-flight reads discarded, no rvalid after reset release; FSM NORMAL.
- bm_req dropped before grant: counter cleared, no access issued.

## Structure
- Shared package dmem_pkg: owner tag enum (OWN_NONE, OWN_CPU, OWN_BM), FSM state enum, default ADDR_W/DATA_W.
- One sub-module: dmem_rd_pipe (parameterised RD_LAT tag shift register with async reset); arbiter FSM, counter and muxing in the top.

## Test plan
- CPU only: read addr 0x0010 (mem returns 0xBEEF) → mem_en=1, mem_we=0 same cycle; cpu_rvalid=1, cpu_rdata=0xBEEF exactly 2 cycles later; cpu_stall=0 throughout.
- Bitmap only, 3 back-to-back reads at 0x0100..0x0102 → bm_gnt each cycle; bm_rvalid on cycles 2,3,4 with matching data.
- Contention: cpu_req and bm_req continuous from cycle 0 → CPU granted cycles 0–3, bm_gnt and cpu_stall=1 in cycle 4, CPU resumes cycle 5.
- Interleave: CPU read cycle 0, bitmap read cycle 1 → cpu_rvalid cycle 2, bm_rvalid cycle 3, data not crossed.
- CPU write 0x1234 to 0x0020 → mem_we=1, mem_wdata=0x1234 in cycle 0; no cpu_rvalid ever.
- Reset pulse 1 cycle after a CPU read issue → no cpu_rvalid after release; all outputs 0, wait_cnt 0.
